if_id_skid_stage: RTL and testbench
===================================

Name: if_id_skid_stage

Overview:
- Parametrised successor to the fixed IF/ID pipeline register.
- Holds fetched instruction + PC+4 between fetch and decode using a valid/ready handshake, a 2-entry (main + skid) buffer so back-pressure never drops a beat, branch/jump flush with NOP bubble insertion, and a saturating flush counter.
- Sits between the instruction-memory/PC logic and the decode/register-file stage.

Parameters:
- INS_W, 32, instruction width in bits; must be ≥ 26.
- PC_W, 32, PC width in bits; must be ≥ 29.
- NOP_INS, 32'h0000_0000, value driven on out_ins when no valid entry (INS_W bits).
- CNT_W, 16, width of flush_count.

Ports:
- CLK  in  1  clock; all state updates on the falling edge of CLK.
- RST  in  1  synchronous, active-high reset, sampled on the same falling edge.
- in_valid  in  1  fetch presents a beat.
- in_ready  out  1  stage can accept; equals NOT skid_valid, registered.
- in_ins  in  INS_W  fetched instruction.
- in_pc  in  PC_W  PC+4 of fetched instruction.
- flush  in  1  kill all held and incoming beats (taken branch/jump).
- out_valid  out  1  main entry valid.
- out_ready  in  1  decode consumes the beat.
- out_ins  out  INS_W  main instruction, or NOP_INS when out_valid=0.
- out_pc  out  PC_W  main PC+4.
- out_jump_pc  out  PC_W  {out_pc[PC_W-1:28], out_ins[25:0], 2'b00}, combinational.
- flush_count  out  CNT_W  number of effective flushes, saturating.

Behaviour:
- State: main entry M (valid, ins, pc) and skid entry S (valid, ins, pc).
- Outputs are driven from M only.
- Definitions:
  - acc = in_valid & in_ready
  - deq = out_valid & out_ready
  - Both are evaluated before the falling edge.
- Reset (RST=1 at edge):
  - M.valid=S.valid=0, M.ins=S.ins=NOP_INS, M.pc=S.pc=0, flush_count=0.
  - After reset: out_valid=0, out_ins=NOP_INS, out_pc=0, in_ready=1.
  - All inputs are ignored at a reset edge, and reset has priority over flush.
- Flush (flush=1, RST=0):
  - M.valid=S.valid=0, M.ins=NOP_INS, pc registers hold.
  - An acc beat in the same cycle is consumed and discarded; upstream sees it as accepted.
  - deq in the same cycle is still a valid consumption by decode.
  - flush_count increments by 1 if M.valid|S.valid|acc, and saturates at all-ones.
- Normal transfer (flush=0, RST=0), FIFO order preserved:
  - M empty, acc: M <= in. Latency 1 edge input → output.
  - M empty, no acc: hold (out_ins=NOP_INS).
  - M full, S empty, deq & acc: M <= in (full throughput, 1 beat/cycle).
  - M full, S empty, deq & !acc: M.valid <= 0, M.ins <= NOP_INS.
  - M full, S empty, !deq & acc: S <= in. in_ready=0 from the next cycle.
  - M full, S empty, !deq & !acc: hold.
  - M full, S full (in_ready=0), deq: M <= S, S.valid <= 0. in_ready=1 next cycle.
  - M full, S full, !deq: hold everything.
- Invariants:
  - S.valid=1 implies M.valid=1.
  - No beat is ever duplicated or lost except by flush.
  - in_valid while in_ready=0 has no effect; upstream must hold the beat.
- out_ins/out_pc change only at falling edges; out_jump_pc follows combinationally.
- Widths:
  - out_jump_pc upper bits come from out_pc[PC_W-1:28], giving PC_W-28 bits.
  - Concatenation totals PC_W.

Test Plan:
- Reset, then in_valid=1, in_ins=32'h2002_0005, in_pc=32'h0000_0004, out_ready=1 → after 1 falling edge: out_valid=1, out_ins=32'h2002_0005, out_pc=4. Streaming 4 beats on consecutive cycles yields them in order, one per cycle, with in_ready=1 throughout.
- out_ready=0, send beats A=32'h1111_1111 and B=32'h2222_2222 → after 2 edges: in_ready=0, out_ins=A. Offer beat C; it is not accepted. Raise out_ready → output sequence A, B, then C, with no gap once C is re-offered.
- M and S both full, flush=1 with in_valid=1 → next edge: out_valid=0, out_ins=NOP_INS, in_ready=1, flush_count=1. A flush with no valid entries and in_valid=0 leaves flush_count unchanged.
- RST=1 and flush=1 at the same edge with both entries full → all valid bits 0, flush_count=0. Mid-stream reset drops all held beats.
- out_pc=32'hA000_0010, out_ins=32'h0800_0040 → out_jump_pc=32'hA000_0100.
- CNT_W=2 instance: 5 effective flushes → flush_count sequence 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline stage: main + skid entry with valid/ready handshake,
// branch/jump flush with NOP bubbles and a saturating flush counter.
module if_id_skid_stage #(
  parameter int               INS_W   = 32,
  parameter int               PC_W    = 32,
  parameter logic [INS_W-1:0] NOP_INS = 32'h0000_0000,
  parameter int               CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INS_W-1:0] in_ins,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INS_W-1:0] out_ins,
  output logic [PC_W-1:0]  out_pc,
  output logic [PC_W-1:0]  out_jump_pc,
  output logic [CNT_W-1:0] flush_count
);

  logic             m_valid_r, s_valid_r, in_ready_r;
  logic [INS_W-1:0] m_ins_r, s_ins_r;
  logic [PC_W-1:0]  m_pc_r, s_pc_r;
  logic [CNT_W-1:0] cnt_r;

  logic             m_valid_nxt_s, s_valid_nxt_s;
  logic [INS_W-1:0] m_ins_nxt_s, s_ins_nxt_s;
  logic [PC_W-1:0]  m_pc_nxt_s, s_pc_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             acc_s, deq_s;

  // Next-state for both entries and the flush counter.
  always_comb begin
    acc_s         = in_valid & in_ready_r;
    deq_s         = m_valid_r & out_ready;
    m_valid_nxt_s = m_valid_r;
    m_ins_nxt_s   = m_ins_r;
    m_pc_nxt_s    = m_pc_r;
    s_valid_nxt_s = s_valid_r;
    s_ins_nxt_s   = s_ins_r;
    s_pc_nxt_s    = s_pc_r;
    cnt_nxt_s     = cnt_r;

    if (flush) begin
      // An accepted beat in this cycle is swallowed; PCs are left as they are.
      m_valid_nxt_s = 1'b0;
      s_valid_nxt_s = 1'b0;
      m_ins_nxt_s   = NOP_INS;
      if ((m_valid_r | s_valid_r | acc_s) && (cnt_r != {CNT_W{1'b1}})) begin
        cnt_nxt_s = cnt_r + CNT_W'(1);
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end else begin
      case ({m_valid_r, s_valid_r})
        2'b00: begin
          if (acc_s) begin
            m_valid_nxt_s = 1'b1;
            m_ins_nxt_s   = in_ins;
            m_pc_nxt_s    = in_pc;
          end else begin
            m_valid_nxt_s = 1'b0;
          end
        end
        2'b10: begin
          case ({deq_s, acc_s})
            2'b11: begin
              m_ins_nxt_s = in_ins;
              m_pc_nxt_s  = in_pc;
            end
            2'b10: begin
              m_valid_nxt_s = 1'b0;
              m_ins_nxt_s   = NOP_INS;
            end
            2'b01: begin
              s_valid_nxt_s = 1'b1;
              s_ins_nxt_s   = in_ins;
              s_pc_nxt_s    = in_pc;
            end
            default: begin
              m_valid_nxt_s = m_valid_r;
            end
          endcase
        end
        2'b11: begin
          if (deq_s) begin
            m_ins_nxt_s   = s_ins_r;
            m_pc_nxt_s    = s_pc_r;
            s_valid_nxt_s = 1'b0;
          end else begin
            s_valid_nxt_s = s_valid_r;
          end
        end
        default: begin
          // Skid without main is unreachable; drop the orphan to recover.
          s_valid_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // State register, updated on the falling edge with synchronous reset.
  always_ff @(negedge CLK) begin
    if (RST) begin
      m_valid_r  <= 1'b0;
      s_valid_r  <= 1'b0;
      m_ins_r    <= NOP_INS;
      s_ins_r    <= NOP_INS;
      m_pc_r     <= {PC_W{1'b0}};
      s_pc_r     <= {PC_W{1'b0}};
      in_ready_r <= 1'b1;
      cnt_r      <= {CNT_W{1'b0}};
    end else begin
      m_valid_r  <= m_valid_nxt_s;
      s_valid_r  <= s_valid_nxt_s;
      m_ins_r    <= m_ins_nxt_s;
      s_ins_r    <= s_ins_nxt_s;
      m_pc_r     <= m_pc_nxt_s;
      s_pc_r     <= s_pc_nxt_s;
      in_ready_r <= ~s_valid_nxt_s;
      cnt_r      <= cnt_nxt_s;
    end
  end

  // m_ins_r is forced to NOP_INS whenever the main entry empties.
  assign in_ready    = in_ready_r;
  assign out_valid   = m_valid_r;
  assign out_ins     = m_ins_r;
  assign out_pc      = m_pc_r;
  assign out_jump_pc = {m_pc_r[PC_W-1:28], m_ins_r[25:0], 2'b00};
  assign flush_count = cnt_r;

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Randomized + directed bench for if_id_skid_stage with a queue-based
// reference model and a scoreboard monitor.
module tb_if_id_skid_stage;
  localparam int INS_W = 32;
  localparam int PC_W  = 32;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] in_ins = 32'h0, in_pc = 32'h0;
  logic in_ready, out_valid, in_ready2, out_valid2;
  logic [31:0] out_ins, out_pc, out_jump_pc, out_ins2, out_pc2, out_jump_pc2;
  logic [15:0] flush_count;
  logic [1:0]  flush_count2;

  always #5 CLK = ~CLK;

  if_id_skid_stage #(.INS_W(32), .PC_W(32), .NOP_INS(32'h0000_0000), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_ins(out_ins), .out_pc(out_pc), .out_jump_pc(out_jump_pc), .flush_count(flush_count));

  if_id_skid_stage #(.INS_W(32), .PC_W(32), .NOP_INS(32'h0000_0000), .CNT_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready2), .in_ins(in_ins),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid2), .out_ready(out_ready),
    .out_ins(out_ins2), .out_pc(out_pc2), .out_jump_pc(out_jump_pc2), .flush_count(flush_count2));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit pushed_now = 1'b0;
  logic [63:0] exp_q[$];   // {ins, pc} of beats held by the stage, oldest first
  int cnt_m = 0;
  int cnt2_m = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; inputs change just after the rising edge.
  task automatic cycle(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit rdy, input bit fl, input bit rst);
    @(posedge CLK);
    #1;
    in_valid  = v;
    in_ins    = ins;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
    RST       = rst;
    pushed_now = v && !fl && !rst && (exp_q.size() < 2);
    if (pushed_now) exp_q.push_back({ins, pc});
  endtask

  // Monitor: compare presented outputs, then retire what the next edge does.
  initial begin
    int sz_b;
    bit exp_vld, acc;
    logic [31:0] h_ins, h_pc;
    forever begin
      @(posedge CLK);
      #2;
      sz_b    = exp_q.size() - int'(pushed_now);
      exp_vld = (sz_b > 0);
      h_ins   = exp_q.size() > 0 ? exp_q[0][63:32] : NOP;
      h_pc    = exp_q.size() > 0 ? exp_q[0][31:0]  : 32'h0;
      if (chk_en) begin
        chk("in_ready", 64'(in_ready), 64'(sz_b < 2));
        chk("out_valid", 64'(out_valid), 64'(exp_vld));
        chk("flush_count", 64'(flush_count), 64'(cnt_m));
        chk("flush_count2", 64'(flush_count2), 64'(cnt2_m));
        chk("out_valid2", 64'(out_valid2), 64'(exp_vld));
        if (exp_vld) begin
          chk("out_ins", 64'(out_ins), 64'(h_ins));
          chk("out_pc", 64'(out_pc), 64'(h_pc));
          chk("out_jump_pc", 64'(out_jump_pc), 64'({h_pc[31:28], h_ins[25:0], 2'b00}));
          chk("out_ins2", 64'(out_ins2), 64'(h_ins));
        end else begin
          chk("out_ins_nop", 64'(out_ins), 64'(NOP));
        end
      end
      acc = in_valid && (sz_b < 2);
      if (RST) begin
        exp_q.delete();
        cnt_m  = 0;
        cnt2_m = 0;
      end else begin
        if (exp_vld && out_ready) void'(exp_q.pop_front());
        if (flush) begin
          if (sz_b > 0 || acc) begin
            if (cnt_m < 65535) cnt_m++;
            if (cnt2_m < 3) cnt2_m++;
          end
          exp_q.delete();
        end
      end
    end
  end

  initial begin
    logic [31:0] r_ins, r_pc;
    bit hv, v, rdy, fl, rst;
    int exp_seq[5] = '{1, 2, 3, 3, 3};

    cycle(1'b1, 32'hDEAD_BEEF, 32'h10, 1'b1, 1'b1, 1'b1);
    @(negedge CLK);
    #1;
    chk_en = 1'b1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_ins", 64'(out_ins), 64'(NOP));
    chk("rst_out_pc", 64'(out_pc), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    // First beat: latency one falling edge
    cycle(1'b1, 32'h2002_0005, 32'h0000_0004, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 32'h3000_0000 + 32'(i), 32'h0000_0008 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
      if (i == 0) begin
        #2;
        chk("first_ins", 64'(out_ins), 64'(32'h2002_0005));
        chk("first_pc", 64'(out_pc), 64'(32'h0000_0004));
      end
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Back-pressure: A, B fill both entries; C waits
    cycle(1'b1, 32'h1111_1111, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h2222_2222, 32'h0000_0104, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h3333_3333, 32'h0000_0108, 1'b0, 1'b0, 1'b0);
    #2;
    chk("bp_in_ready", 64'(in_ready), 64'(0));
    chk("bp_out_ins", 64'(out_ins), 64'(32'h1111_1111));
    cycle(1'b1, 32'h3333_3333, 32'h0000_0108, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h3333_3333, 32'h0000_0108, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Flush with both entries full, then an ineffective flush
    cycle(1'b1, 32'h4444_4444, 32'h0000_0200, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h5555_5555, 32'h0000_0204, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h6666_6666, 32'h0000_0208, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    #2;
    chk("fl_out_valid", 64'(out_valid), 64'(0));
    chk("fl_out_ins", 64'(out_ins), 64'(NOP));
    chk("fl_in_ready", 64'(in_ready), 64'(1));
    chk("fl_count", 64'(flush_count), 64'(1));
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("fl_idle_count", 64'(flush_count), 64'(1));

    // Reset beats flush at the same edge
    cycle(1'b1, 32'h7777_7777, 32'h0000_0300, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h8888_8888, 32'h0000_0304, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h9999_9999, 32'h0000_0308, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("rstfl_valid", 64'(out_valid), 64'(0));
    chk("rstfl_count", 64'(flush_count), 64'(0));

    // Jump target composition
    cycle(1'b1, 32'h0800_0040, 32'hA000_0010, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("jump_pc", 64'(out_jump_pc), 64'(32'hA000_0100));
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Narrow counter saturation: 5 effective flushes
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 32'hC000_0000 + 32'(k), 32'h400, 1'b0, 1'b1, 1'b0);
      @(negedge CLK);
      #1;
      chk("cnt2_seq", 64'(flush_count2), 64'(exp_seq[k]));
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Random traffic; an unaccepted beat is held until taken or flushed
    hv = 1'b0;
    r_ins = 32'h0;
    r_pc = 32'h0;
    for (int n = 0; n < 800; n++) begin
      if (!hv && ($urandom_range(3) != 0)) begin
        hv    = 1'b1;
        r_ins = $urandom;
        r_pc  = $urandom;
      end
      v   = hv;
      rdy = ($urandom_range(2) != 0);
      fl  = ($urandom_range(15) == 0);
      rst = ($urandom_range(99) == 0);
      cycle(v, r_ins, r_pc, rdy, fl, rst);
      if (pushed_now || (fl && !rst)) hv = 1'b0;
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    @(posedge CLK);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
